// File: rtl/fetch_unit_pkg.sv
// Shared widths, reset instruction, fetch FSM encodings and the fetch buffer payload.
package fetch_unit_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned INSN_WIDTH = 32;
  localparam logic [INSN_WIDTH-1:0] NOP_INSN = 32'h0000_0013;
  localparam logic [DATA_WIDTH-1:0] PC_ALIGN_MASK = ~DATA_WIDTH'(3);

  // Encodings are fixed so trace/debug logic can decode the state directly.
  typedef enum logic [2:0] {
    FS_REQ   = 3'd0,
    FS_WAIT  = 3'd1,
    FS_ISSUE = 3'd2,
    FS_EXEC  = 3'd3,
    FS_TRAP  = 3'd4
  } fetch_state_e;

  typedef struct packed {
    logic [INSN_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
  } if_entry_t;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Architectural PC register: resettable, enable-gated, forces word alignment on load.
module fetch_unit_pc_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_PC;
    end else if (en) begin
      q <= d & PC_ALIGN_MASK;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: one outstanding imem request, single-entry decode buffer.
// Optional FETCH_MISALIGN_TRAP_EN traps misaligned commit targets instead of masking them.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [DATA_WIDTH-1:0] pc_current,
  input  logic [DATA_WIDTH-1:0] pc_next,
  input  logic                  pc_we,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [INSN_WIDTH-1:0] imem_resp_data,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [INSN_WIDTH-1:0] if_instr,
  output logic [DATA_WIDTH-1:0] if_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic                  fetch_misaligned
`endif
);

  fetch_state_e state, next_state;
  logic         pc_en;
  logic         buf_load;
  if_entry_t    buf_q;

  fetch_unit_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pc_en),
    .d     (pc_next),
    .q     (pc_current)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FS_REQ;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and load strobes; inputs outside their owning state are ignored
  always_comb begin
    next_state = state;
    pc_en      = 1'b0;
    buf_load   = 1'b0;
    case (state)
      FS_REQ: begin
        if (imem_req_ready) next_state = FS_WAIT;
      end
      FS_WAIT: begin
        if (imem_resp_valid) begin
          buf_load   = 1'b1;
          next_state = FS_ISSUE;
        end
      end
      FS_ISSUE: begin
        if (if_ready) next_state = FS_EXEC;
      end
      FS_EXEC: begin
        if (pc_we) begin
`ifdef FETCH_MISALIGN_TRAP_EN
          if (|pc_next[1:0]) begin
            next_state = FS_TRAP;
          end else begin
            pc_en      = 1'b1;
            next_state = FS_REQ;
          end
`else
          pc_en      = 1'b1;
          next_state = FS_REQ;
`endif
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      FS_TRAP: begin
        next_state = FS_TRAP;
      end
`endif
      default: begin
        next_state = FS_REQ;
      end
    endcase
  end

  // Decode buffer: captured once per fetch, held while decode back-pressures
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '{instr: NOP_INSN, pc: RESET_PC};
    end else if (buf_load) begin
      buf_q <= '{instr: imem_resp_data, pc: pc_current};
    end
  end

  assign imem_req_valid = (state == FS_REQ);
  assign imem_req_addr  = pc_current;
  assign if_valid       = (state == FS_ISSUE);
  assign if_instr       = buf_q.instr;
  assign if_pc          = buf_q.pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  // TRAP only leaves on reset, so the flag is sticky by construction
  assign fetch_misaligned = (state == FS_TRAP);
`endif

endmodule
